add_tree_block: RTL

Parametrised, pipelined N-channel adder tree with a valid/ready handshake. It generalises the team's two-input registered averaging adder to NUM_CH inputs, signed or unsigned data, and a selectable output mode: mean, saturate or full width. It sits in the sample datapath wherever several equal-width channels must be combined, for example in beam or channel summing and decimating averagers.

---
 rtl/add_pkg.sv | 26 ++
 rtl/add_tree_level.sv | 35 +++
 rtl/add_tree_block.sv | 115 +++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
package add_pkg;

  localparam int OUT_MEAN = 0;
  localparam int OUT_SAT  = 1;
  localparam int OUT_FULL = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Clamp bounds for a w-bit result, returned as raw 64-bit two's complement.
  function automatic logic [63:0] sat_max(input int w, input bit sgn);
    return sgn ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w, input bit sgn);
    return sgn ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered level of the adder tree: N_IN operands reduced pairwise to
// N_IN/2 sums, each one bit wider than its inputs.
module add_tree_level #(
  parameter int IN_W      = 12,
  parameter int N_IN      = 2,
  parameter int IS_SIGNED = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [N_IN*IN_W-1:0]           data_i,
  output logic [(N_IN/2)*(IN_W+1)-1:0]   data_o
);

  localparam int N_OUT = N_IN / 2;
  localparam int OW    = IN_W + 1;

  logic [N_OUT-1:0][OW-1:0] sum_d, sum_q;

  for (genvar p = 0; p < N_OUT; p++) begin : g_pair
    logic [IN_W-1:0] a, b;
    assign a = data_i[(2*p)*IN_W +: IN_W];
    assign b = data_i[(2*p+1)*IN_W +: IN_W];
    assign sum_d[p] = {(IS_SIGNED != 0) & a[IN_W-1], a}
                    + {(IS_SIGNED != 0) & b[IN_W-1], b};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   sum_q <= '0;
    else if (en_i) sum_q <= sum_d;
  end

  assign data_o = sum_q;

endmodule

// File: rtl/add_tree_block.sv
// Pipelined NUM_CH-input adder tree with mean / saturate / full output modes
// and a single global advance for valid/ready flow control.
module add_tree_block
  import add_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int NUM_CH    = 2,
  parameter int IS_SIGNED = 0,
  parameter int OUT_MODE  = 0,
  parameter int ROUND     = 0,
  localparam int L        = clog2(NUM_CH)
) (
  input  logic                     ip_clock,
  input  logic                     ip_reset,
  input  logic [NUM_CH*DATA_W-1:0] ip_data,
  input  logic                     ip_valid,
  output logic                     ip_ready,
  output logic [DATA_W-1:0]        op_data,
  output logic [DATA_W+L-1:0]      op_sum,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic                     op_ovf,
  input  logic                     ip_clr_ovf,
  output logic                     op_ovf_sticky
);

  localparam int SW = DATA_W + L;
  localparam logic [DATA_W-1:0] MAXV    = DATA_W'(sat_max(DATA_W, IS_SIGNED != 0));
  localparam logic [DATA_W-1:0] MINV    = DATA_W'(sat_min(DATA_W, IS_SIGNED != 0));
  localparam logic [SW:0]       RND_ADD = (ROUND != 0) ? ((SW+1)'(1) << (L - 1)) : '0;

  if (NUM_CH < 2 || NUM_CH > 16 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_ch
    $error("add_tree_block: NUM_CH must be a power of two in 2..16");
  end
  if (OUT_MODE < OUT_MEAN || OUT_MODE > OUT_FULL) begin : g_bad_mode
    $error("add_tree_block: OUT_MODE must be 0..2");
  end

  logic         advance;
  logic [L-1:0] vld_pipe_q;
  logic         sticky_q, sticky_d;

  assign op_valid = vld_pipe_q[L-1];
  assign advance  = op_ready | ~op_valid;
  assign ip_ready = advance;

  always_ff @(posedge ip_clock or negedge ip_reset) begin
    if (!ip_reset)    vld_pipe_q <= '0;
    else if (advance) vld_pipe_q <= L'({vld_pipe_q, ip_valid});
  end

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int IW = DATA_W + i;
    localparam int NI = NUM_CH >> i;
    logic [NI*IW-1:0]         lvl_in;
    logic [(NI/2)*(IW+1)-1:0] lvl_q;
    if (i == 0) begin : g_first
      assign lvl_in = ip_data;
    end else begin : g_next
      assign lvl_in = g_lvl[i-1].lvl_q;
    end
    add_tree_level #(.IN_W(IW), .N_IN(NI), .IS_SIGNED(IS_SIGNED)) u_lvl (
      .clk_i  (ip_clock),
      .rst_ni (ip_reset),
      .en_i   (advance),
      .data_i (lvl_in),
      .data_o (lvl_q)
    );
  end

  logic [SW-1:0] sum;
  logic [SW:0]   rnd_sum;
  logic          sat_hi, sat_lo;
  logic          rnd_unused;

  assign sum = g_lvl[L-1].lvl_q;
  // Guard bit keeps the rounding add exact; the slice below is the (arithmetic) shift.
  assign rnd_sum    = {(IS_SIGNED != 0) & sum[SW-1], sum} + RND_ADD;
  assign rnd_unused = ^{rnd_sum[SW], rnd_sum[L-1:0]};

  always_comb begin
    if (IS_SIGNED != 0) begin
      sat_hi = !sum[SW-1] && (sum[SW-1:DATA_W-1] != '0);
      sat_lo =  sum[SW-1] && (sum[SW-1:DATA_W-1] != '1);
    end else begin
      sat_hi = (sum[SW-1:DATA_W] != '0);
      sat_lo = 1'b0;
    end
  end

  always_comb begin
    op_sum  = sum;
    op_ovf  = 1'b0;
    op_data = sum[DATA_W-1:0];
    case (OUT_MODE)
      OUT_MEAN: op_data = rnd_sum[L +: DATA_W];
      OUT_SAT: begin
        op_ovf  = sat_hi | sat_lo;
        op_data = sat_hi ? MAXV : (sat_lo ? MINV : sum[DATA_W-1:0]);
      end
      default: ;
    endcase
  end

  // A saturating transfer beats a simultaneous clear.
  assign sticky_d = (op_valid & op_ready & op_ovf) | (sticky_q & ~ip_clr_ovf);

  always_ff @(posedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) sticky_q <= 1'b0;
    else           sticky_q <= sticky_d;
  end

  assign op_ovf_sticky = sticky_q;

endmodule
